sum_seq_cla: RTL

//  Multi-cycle, parametrised carry-lookahead adder/subtractor for the arithmetic lab datapath.

---
 rtl/sum_seq_cla_pkg.sv | 34 +++
 rtl/sum_seq_cla_if.sv | 35 +++
 rtl/cla_slice.sv | 61 ++++++
 rtl/sum_seq_cla.sv | 127 ++++++++++++
 4 files changed

// File: rtl/sum_seq_cla_pkg.sv
// ============================================================================
//  Module : sum_seq_cla_pkg
//  Desc   : Shared FSM encodings and the 4-bit carry-lookahead helper for the
//           sequential CLA adder/subtractor.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sum_seq_cla_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef struct packed {
        logic [3:0] c;   // carry into each bit of the group, c[0] = group carry-in
        logic       gg;  // group generate
        logic       gp;  // group propagate
    } cla4_t;

    function automatic cla4_t cla4(input logic [3:0] g, input logic [3:0] p, input logic ci);
        cla4_t r;
        r.c[0] = ci;
        r.c[1] = g[0] | (p[0] & ci);
        r.c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        r.c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        r.gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        r.gp   = &p;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sum_seq_cla_if.sv
// ============================================================================
//  Module : sum_seq_cla_if
//  Desc   : Start/done handshake and operand/result bus of the sequential adder.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sum_seq_cla_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             Cout;
    logic             ovf;
    logic             G;
    logic             P;

    modport master (
        output start, a, b, c_in, sub,
        input  busy, done, sum, Cout, ovf, G, P
    );

    modport slave (
        input  start, a, b, c_in, sub,
        output busy, done, sum, Cout, ovf, G, P
    );
endinterface

`default_nettype wire

// File: rtl/cla_slice.sv
// ============================================================================
//  Module : cla_slice
//  Desc   : Combinational SLICE-bit carry-lookahead slice built from 4-bit
//           lookahead groups chained by a group carry unit.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cla_slice
    import sum_seq_cla_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  wire logic [SLICE-1:0] i_a,
    input  wire logic [SLICE-1:0] i_b,
    input  wire logic             i_cin,
    output logic      [SLICE-1:0] o_s,
    output logic                  o_g,
    output logic                  o_p,
    output logic                  o_cout,
    output logic                  o_c_msb
);
    localparam int NG = SLICE / 4;

    logic [SLICE-1:0] w_g;
    logic [SLICE-1:0] w_p;
    logic [SLICE-1:0] w_c;
    logic             w_gacc;
    logic             w_pacc;
    logic             w_cout;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    always_comb begin
        logic  c;
        cla4_t r;
        w_c    = '0;
        w_gacc = 1'b0;
        w_pacc = 1'b1;
        r      = '0;
        c      = i_cin;
        for (int k = 0; k < NG; k++) begin
            r              = cla4(w_g[4*k +: 4], w_p[4*k +: 4], c);
            w_c[4*k +: 4]  = r.c;
            w_gacc         = r.gg | (r.gp & w_gacc);
            w_pacc         = w_pacc & r.gp;
            c              = r.gg | (r.gp & c);
        end
        w_cout = c;
    end

    assign o_s     = w_p ^ w_c;
    assign o_g     = w_gacc;
    assign o_p     = w_pacc;
    assign o_cout  = w_cout;
    assign o_c_msb = w_c[SLICE-1];

endmodule

`default_nettype wire

// File: rtl/sum_seq_cla.sv
// ============================================================================
//  Module : sum_seq_cla
//  Desc   : Multi-cycle CLA adder/subtractor, one SLICE-bit slice per clock,
//           with start/done handshake, carry-out, overflow and word G/P.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sum_seq_cla
    import sum_seq_cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  wire logic  clk,
    input  wire logic  reset,
    sum_seq_cla_if.slave bus
);
    localparam int             N      = WIDTH / SLICE;
    localparam int             IW     = $clog2(N);
    localparam logic [IW-1:0]  C_LAST = IW'(N - 1);

    logic [1:0]       r_state;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic             r_gacc;
    logic             r_pacc;
    logic [WIDTH-1:0] r_sum_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_g;
    logic             r_p;

    logic [SLICE-1:0] w_s;
    logic             w_g;
    logic             w_p;
    logic             w_cout;
    logic             w_c_msb;
    logic             w_gacc_nxt;
    logic             w_pacc_nxt;
    logic [WIDTH-1:0] w_sum_nxt;

    // Operands shift right each RUN cycle so the active slice is always the low bits
    cla_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .i_a     (r_a[SLICE-1:0]),
        .i_b     (r_b[SLICE-1:0]),
        .i_cin   (r_carry),
        .o_s     (w_s),
        .o_g     (w_g),
        .o_p     (w_p),
        .o_cout  (w_cout),
        .o_c_msb (w_c_msb)
    );

    assign w_gacc_nxt = w_g | (w_p & r_gacc);
    assign w_pacc_nxt = r_pacc & w_p;
    assign w_sum_nxt  = {w_s, r_sum_sh[WIDTH-1:SLICE]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_gacc   <= 1'b0;
            r_pacc   <= 1'b0;
            r_sum_sh <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_g      <= 1'b0;
            r_p      <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_a      <= r_a >> SLICE;
                    r_b      <= r_b >> SLICE;
                    r_carry  <= w_cout;
                    r_gacc   <= w_gacc_nxt;
                    r_pacc   <= w_pacc_nxt;
                    r_sum_sh <= w_sum_nxt;
                    if (r_idx == C_LAST) begin
                        r_idx   <= '0;
                        r_sum   <= w_sum_nxt;
                        r_cout  <= w_cout;
                        r_ovf   <= w_c_msb ^ w_cout;
                        r_g     <= w_gacc_nxt;
                        r_p     <= w_pacc_nxt;
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                    end
                end
                default: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.sub ? ~bus.b : bus.b;
                        r_carry <= bus.sub ? 1'b1 : bus.c_in;
                        r_idx   <= '0;
                        r_gacc  <= 1'b0;
                        r_pacc  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy = (r_state == S_RUN);
    assign bus.done = (r_state == S_DONE);
    assign bus.sum  = r_sum;
    assign bus.Cout = r_cout;
    assign bus.ovf  = r_ovf;
    assign bus.G    = r_g;
    assign bus.P    = r_p;

endmodule

`default_nettype wire
